// File: rtl/issue_pkg.sv
// Shared types and constants for the in-order issue engine and its scoreboard.
package issue_pkg;

  localparam int REG_W     = 5;
  localparam int NUM_REGS  = 32;
  localparam int LAT_W_MAX = 8;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [REG_W-1:0]     rs;
    logic [REG_W-1:0]     rt;
    logic                 rs_used;
    logic                 rt_used;
    logic [REG_W-1:0]     dest;
    logic                 wb_en;
    logic [LAT_W_MAX-1:0] lat;
    logic [1:0]           mem_type;
    logic                 branch;
    logic                 priv;
  } lane_info_t;

  // True when the lane actually reads architectural register r (r0 never counts).
  function automatic logic reads_reg(lane_info_t li, logic [REG_W-1:0] r);
    return (r != '0) && ((li.rs_used && (li.rs == r)) || (li.rt_used && (li.rt == r)));
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register latency scoreboard: a register is busy while its counter is nonzero.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int LANES = 2,
  parameter int LAT_W = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             flush,
  input  logic [LANES-1:0]                 ld_en,
  input  logic [LANES-1:0][REG_W-1:0]      ld_dest,
  input  logic [LANES-1:0][LAT_W-1:0]      ld_lat,
  output logic [NUM_REGS-1:0]              busy
);

  // r0 is hardwired idle, so it has no counter at all.
  logic [LAT_W-1:0] cnt_q [1:NUM_REGS-1];
  logic [LAT_W-1:0] cnt_d [1:NUM_REGS-1];

  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!stall && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      // Ascending scan lets the highest-numbered lane win a shared dest.
      for (int k = 0; k < LANES; k++) begin
        if (ld_en[k] && (ld_dest[k] == REG_W'(r))) begin
          cnt_d[r] = ld_lat[k];
        end
      end
      if (flush) begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    busy[0] = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

endmodule

// File: rtl/issue_engine.sv
// N-lane in-order issue selector with hazard scoreboard and privileged-drain FSM.
// Optional perf counters are built when ISSUE_ENGINE_PERF_EN is defined.
module issue_engine
  import issue_pkg::*;
#(
  parameter int LANES = 2,
  parameter int LAT_W = 3,
  parameter int CNT_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CNT_W-1:0]               fifo_count,
  input  logic [LANES-1:0][REG_W-1:0]    id_rs,
  input  logic [LANES-1:0][REG_W-1:0]    id_rt,
  input  logic [LANES-1:0]               id_rs_used,
  input  logic [LANES-1:0]               id_rt_used,
  input  logic [LANES-1:0][REG_W-1:0]    id_wb_reg_dest,
  input  logic [LANES-1:0]               id_wb_reg_en,
  input  logic [LANES-1:0][LAT_W-1:0]    id_lat,
  input  logic [LANES-1:0][1:0]          id_mem_type,
  input  logic [LANES-1:0]               id_is_branch_instr,
  input  logic [LANES-1:0]               id_priv_inst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           pipe_empty,
  output logic [LANES-1:0]               issue_en,
  output logic [$clog2(LANES+1)-1:0]     issue_count
`ifdef ISSUE_ENGINE_PERF_EN
  ,
  output logic [31:0]                    perf_issue_cycles,
  output logic [31:0]                    perf_multi_cycles
`endif
);

  localparam int CW = $clog2(LANES+1);

  lane_info_t            lane [LANES];
  logic [LANES-1:0]      issue;
  logic [LANES-1:0]      ld_en;
  logic [NUM_REGS-1:0]   busy;
  issue_state_t          state_q, state_d;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane[k].rs       = id_rs[k];
      lane[k].rt       = id_rt[k];
      lane[k].rs_used  = id_rs_used[k];
      lane[k].rt_used  = id_rt_used[k];
      lane[k].dest     = id_wb_reg_dest[k];
      lane[k].wb_en    = id_wb_reg_en[k];
      lane[k].lat      = LAT_W_MAX'(id_lat[k]);
      lane[k].mem_type = id_mem_type[k];
      lane[k].branch   = id_is_branch_instr[k];
      lane[k].priv     = id_priv_inst[k];
    end
  end

  // A branch may lead a group; only trailing lanes are restricted by class.
  logic unused_lane0_branch;
  assign unused_lane0_branch = lane[0].branch;

  always_comb begin
    logic ok;
    logic prev;
    issue = '0;
    prev  = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      ok = prev && (int'(fifo_count) > k);
      if (k == 0) begin
        ok = ok && !stall && !flush && !rst && (state_q == NORMAL);
      end else begin
        ok = ok && !lane[k].branch && !lane[k].priv && !lane[0].priv;
      end
      if ((lane[k].rs_used && busy[lane[k].rs]) || (lane[k].rt_used && busy[lane[k].rt])) begin
        ok = 1'b0;
      end
      for (int j = 0; j < k; j++) begin
        if (lane[j].wb_en && reads_reg(lane[k], lane[j].dest)) begin
          ok = 1'b0;
        end
        if ((lane[j].mem_type != '0) && (lane[k].mem_type != '0)) begin
          ok = 1'b0;
        end
      end
      issue[k] = ok;
      prev     = ok;
    end
  end

  always_comb begin
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      cnt = cnt + CW'(issue[k]);
      ld_en[k] = issue[k] && lane[k].wb_en && (lane[k].dest != '0) && (lane[k].lat != '0);
    end
    issue_en    = issue;
    issue_count = cnt;
  end

  issue_scoreboard #(
    .LANES (LANES),
    .LAT_W (LAT_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .flush   (flush),
    .ld_en   (ld_en),
    .ld_dest (id_wb_reg_dest),
    .ld_lat  (id_lat),
    .busy    (busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = NORMAL;
    end else begin
      case (state_q)
        NORMAL:  if (issue[0] && lane[0].priv) state_d = DRAIN;
        DRAIN:   if (pipe_empty) state_d = NORMAL;
        default: state_d = NORMAL;
      endcase
    end
  end

`ifdef ISSUE_ENGINE_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_multi_q, perf_multi_d;

  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_multi_d = perf_multi_q;
    if (issue_count != '0) perf_issue_d = perf_issue_q + 32'd1;
    if (issue_count > CW'(1)) perf_multi_d = perf_multi_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_q <= '0;
      perf_multi_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_multi_q <= perf_multi_d;
    end
  end

  assign perf_issue_cycles = perf_issue_q;
  assign perf_multi_cycles = perf_multi_q;
`endif

endmodule

// File: tb/tb_issue_engine.sv
// Self-checking bench for issue_engine: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model of the issue rules.
module tb_issue_engine;

  localparam int LANES = 2;
  localparam int LAT_W = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0]             fifo_count = '0;
  logic [LANES-1:0][4:0]        id_rs = '0, id_rt = '0, id_wb_reg_dest = '0;
  logic [LANES-1:0]             id_rs_used = '0, id_rt_used = '0, id_wb_reg_en = '0;
  logic [LANES-1:0][LAT_W-1:0]  id_lat = '0;
  logic [LANES-1:0][1:0]        id_mem_type = '0;
  logic [LANES-1:0]             id_is_branch_instr = '0, id_priv_inst = '0;
  logic stall = 1'b0, flush = 1'b0, pipe_empty = 1'b0;
  logic [LANES-1:0]             issue_en;
  logic [$clog2(LANES+1)-1:0]   issue_count;
`ifdef ISSUE_ENGINE_PERF_EN
  logic [31:0] perf_issue_cycles, perf_multi_cycles;
  int unsigned m_perf_i = 0, m_perf_m = 0;
`endif

  int checks = 0;
  int failures = 0;

  // Model state: cycles each register is still owed, and whether we are draining.
  int mcnt [32];
  bit mdrain = 1'b0;

  issue_engine #(.LANES(LANES), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fifo_count(fifo_count),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wb_reg_dest(id_wb_reg_dest), .id_wb_reg_en(id_wb_reg_en), .id_lat(id_lat),
    .id_mem_type(id_mem_type), .id_is_branch_instr(id_is_branch_instr),
    .id_priv_inst(id_priv_inst), .stall(stall), .flush(flush), .pipe_empty(pipe_empty),
    .issue_en(issue_en), .issue_count(issue_count)
`ifdef ISSUE_ENGINE_PERF_EN
    , .perf_issue_cycles(perf_issue_cycles), .perf_multi_cycles(perf_multi_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit src_owed(int k);
    bit owed = 1'b0;
    if (id_rs_used[k] && id_rs[k] != 0 && mcnt[id_rs[k]] != 0) owed = 1'b1;
    if (id_rt_used[k] && id_rt[k] != 0 && mcnt[id_rt[k]] != 0) owed = 1'b1;
    return owed;
  endfunction

  function automatic bit conflicts_earlier(int k);
    bit c = 1'b0;
    for (int j = 0; j < k; j++) begin
      if (id_wb_reg_en[j] && id_wb_reg_dest[j] != 0) begin
        if (id_rs_used[k] && id_rs[k] == id_wb_reg_dest[j]) c = 1'b1;
        if (id_rt_used[k] && id_rt[k] == id_wb_reg_dest[j]) c = 1'b1;
      end
      if (id_mem_type[j] != 0 && id_mem_type[k] != 0) c = 1'b1;
    end
    return c;
  endfunction

  // Longest in-order prefix that may issue this cycle.
  function automatic logic [LANES-1:0] model_issue();
    logic [LANES-1:0] m = '0;
    bit go = 1'b1;
    if (rst || stall || flush || mdrain) return '0;
    for (int k = 0; k < LANES; k++) begin
      if (int'(fifo_count) <= k) go = 1'b0;
      if (k > 0 && (id_is_branch_instr[k] || id_priv_inst[k] || id_priv_inst[0])) go = 1'b0;
      if (src_owed(k) || conflicts_earlier(k)) go = 1'b0;
      if (!go) break;
      m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic int popc(logic [LANES-1:0] v);
    int n = 0;
    for (int k = 0; k < LANES; k++) n += int'(v[k]);
    return n;
  endfunction

  always @(negedge clk) begin
    logic [LANES-1:0] e;
    e = model_issue();
    check("model_issue_en", 32'(issue_en), 32'(e));
    check("model_issue_count", 32'(issue_count), 32'(popc(e)));
`ifdef ISSUE_ENGINE_PERF_EN
    check("model_perf_issue", perf_issue_cycles, m_perf_i);
    check("model_perf_multi", perf_multi_cycles, m_perf_m);
`endif
  end

  always @(posedge clk) begin
    logic [LANES-1:0] e;
    if (rst) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      mdrain = 1'b0;
`ifdef ISSUE_ENGINE_PERF_EN
      m_perf_i = 0; m_perf_m = 0;
`endif
    end else begin
      e = model_issue();
      if (flush) begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        mdrain = 1'b0;
      end else begin
        if (!stall) for (int r = 0; r < 32; r++) if (mcnt[r] > 0) mcnt[r]--;
        for (int k = 0; k < LANES; k++)
          if (e[k] && id_wb_reg_en[k] && id_wb_reg_dest[k] != 0 && id_lat[k] != 0)
            mcnt[id_wb_reg_dest[k]] = int'(id_lat[k]);
        if (!mdrain && e[0] && id_priv_inst[0]) mdrain = 1'b1;
        else if (mdrain && pipe_empty) mdrain = 1'b0;
      end
`ifdef ISSUE_ENGINE_PERF_EN
      if (popc(e) >= 1) m_perf_i++;
      if (popc(e) >= 2) m_perf_m++;
`endif
    end
  end

  task automatic set_lane(input int k, input int rs, input int rt, input bit ru, input bit tu,
                          input int dest, input bit wen, input int lat, input int mem,
                          input bit br, input bit pv);
    id_rs[k] = 5'(rs);  id_rt[k] = 5'(rt);
    id_rs_used[k] = ru; id_rt_used[k] = tu;
    id_wb_reg_dest[k] = 5'(dest); id_wb_reg_en[k] = wen;
    id_lat[k] = LAT_W'(lat); id_mem_type[k] = 2'(mem);
    id_is_branch_instr[k] = br; id_priv_inst[k] = pv;
  endtask

  task automatic alu_lanes();
    set_lane(0, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
    set_lane(1, 4, 6, 1, 1, 7, 1, 0, 0, 0, 0);
  endtask

  // Called at posedge+1 with inputs applied; checks before the next negedge.
  task automatic lit(input string name, input logic [LANES-1:0] exp);
    #3;
    check(name, 32'(issue_en), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    fifo_count = 4'd3;
    alu_lanes();
    @(posedge clk); #1;
    lit("reset_hold", 2'b00);
    rst = 1'b0;

    lit("dual_alu", 2'b11);
    set_lane(0, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
    set_lane(1, 5, 6, 1, 0, 7, 1, 0, 0, 0, 0);
    lit("raw_block", 2'b01);
    set_lane(0, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0);
    lit("raw_r0_dest", 2'b11);

    fifo_count = 4'd1;
    set_lane(0, 1, 0, 1, 0, 8, 1, 2, 1, 0, 0);
    lit("load_issue", 2'b01);
    set_lane(0, 8, 0, 1, 0, 10, 1, 0, 0, 0, 0);
    lit("lu_t1", 2'b00);
    lit("lu_t2", 2'b00);
    lit("lu_t3", 2'b01);
    set_lane(0, 1, 0, 1, 0, 8, 1, 2, 1, 0, 0);
    lit("load_issue2", 2'b01);
    set_lane(0, 8, 0, 1, 0, 10, 1, 0, 0, 0, 0);
    stall = 1'b1;
    lit("lus_t1", 2'b00);
    stall = 1'b0;
    lit("lus_t2", 2'b00);
    lit("lus_t3", 2'b00);
    lit("lus_t4", 2'b01);

    fifo_count = 4'd3;
    set_lane(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    set_lane(1, 2, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    lit("priv_alone", 2'b01);
    alu_lanes();
    lit("drain1", 2'b00);
    lit("drain2", 2'b00);
    pipe_empty = 1'b1;
    lit("drain_pe", 2'b00);
    pipe_empty = 1'b0;
    lit("resume", 2'b11);
    set_lane(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    lit("priv2", 2'b01);
    alu_lanes();
    flush = 1'b1;
    lit("drain_flush", 2'b00);
    flush = 1'b0;
    lit("after_flush", 2'b11);
    set_lane(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    flush = 1'b1;
    lit("flush_priv", 2'b00);
    flush = 1'b0;
    alu_lanes();
    lit("flush_priv_next", 2'b11);

    set_lane(0, 1, 0, 1, 0, 3, 1, 0, 1, 0, 0);
    set_lane(1, 4, 0, 1, 0, 7, 1, 0, 2, 0, 0);
    lit("two_mem", 2'b01);
    alu_lanes();
    id_is_branch_instr[1] = 1'b1;
    lit("branch_lane1", 2'b01);
    id_is_branch_instr[1] = 1'b0;
    fifo_count = 4'd1;
    lit("fifo_one", 2'b01);
    fifo_count = 4'd0;
    lit("fifo_zero", 2'b00);
    fifo_count = 4'd9;
    lit("fifo_sat", 2'b11);

    fifo_count = 4'd3;
    set_lane(0, 1, 0, 1, 0, 9, 1, 7, 0, 0, 1);
    lit("priv_load", 2'b01);
    set_lane(0, 9, 0, 1, 0, 11, 1, 0, 0, 0, 0);
    set_lane(1, 0, 9, 0, 1, 12, 1, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_async", 32'(issue_en), 32'd0);
    check("rst_async_count", 32'(issue_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef ISSUE_ENGINE_PERF_EN
    check("perf_issue_rst", perf_issue_cycles, 32'd0);
    check("perf_multi_rst", perf_multi_cycles, 32'd0);
`endif
    lit("after_rst", 2'b11);

    for (int c = 0; c < 3000; c++) begin
      fifo_count = CNT_W'($urandom_range(0, 5));
      for (int k = 0; k < LANES; k++) begin
        set_lane(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 15) == 0));
      end
      stall      = 1'($urandom_range(0, 6) == 0);
      flush      = 1'($urandom_range(0, 29) == 0);
      pipe_empty = 1'($urandom_range(0, 3) == 0);
      rst        = 1'($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
